// File: rtl/mock_cu_multi.sv
// mock_cu_multi
//   Mock control unit answering a contiguous block of NUM_DEVICES device
//   addresses on channel "B". It runs the bus/tag handshakes for short busy,
//   TEST I/O, NOP, SENSE and a WRITE/READ loopback through an internal byte
//   buffer. Selections for other addresses are passed on to channel "A" so
//   several mock units can be daisy-chained.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   b_bus_out / b_bus_in  channel bus out (from channel) / bus in (to channel)
//   b_*_out               channel tags (hold and suppress are not used)
//   b_*_in                control-unit tags (request is tied low)
//   a_select_out          select propagated downstream
//   a_select_in           select returned from downstream, re-timed onto b_select_in
//   mock_busy             per-device busy, bit i = address BASE_ADDRESS+i
module mock_cu_multi #(
    parameter logic [7:0] BASE_ADDRESS      = 8'h10,
    parameter int         NUM_DEVICES       = 4,
    parameter int         BUFFER_DEPTH      = 16,
    parameter bit         ENABLE_SHORT_BUSY = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             b_bus_out,
    output logic [7:0]             b_bus_in,
    input  logic                   b_operational_out,
    input  logic                   b_hold_out,
    input  logic                   b_select_out,
    input  logic                   b_address_out,
    input  logic                   b_command_out,
    input  logic                   b_service_out,
    input  logic                   b_suppress_out,
    output logic                   b_operational_in,
    output logic                   b_address_in,
    output logic                   b_status_in,
    output logic                   b_service_in,
    output logic                   b_request_in,
    output logic                   b_select_in,
    output logic                   a_select_out,
    input  logic                   a_select_in,
    input  logic [NUM_DEVICES-1:0] mock_busy
);

    localparam int FILL_W = $clog2(BUFFER_DEPTH + 1);
    localparam int BUF_AW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int DEV_W  = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

    localparam logic [7:0] ST_NONE       = 8'h00;
    localparam logic [7:0] ST_BUSY       = 8'h08;
    localparam logic [7:0] ST_SHORT_BUSY = 8'h0C;
    localparam logic [7:0] ST_CEDE       = 8'h30;
    localparam logic [7:0] ST_CEDE_UC    = 8'h70;

    localparam logic [7:0] CMD_TEST  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_NOP   = 8'h03;
    localparam logic [7:0] CMD_SENSE = 8'h04;

    typedef enum logic [3:0] {
        S_IDLE, S_SB, S_SB_ACK, S_ADDR_WAIT, S_ADDR_IN, S_CMD_WAIT, S_DECODE,
        S_ST_INIT, S_ST_INIT_ACK, S_DOUT, S_DOUT_ACK, S_DIN, S_DIN_ACK,
        S_STOP, S_ST_END, S_ST_END_ACK
    } state_t;

    state_t              state_q, state_d;
    logic [DEV_W-1:0]    dev_q, dev_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [7:0]          stat_q, stat_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [FILL_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]          sense_q [NUM_DEVICES];
    logic [7:0]          sense_d [NUM_DEVICES];
    logic [7:0]          data_q  [BUFFER_DEPTH];

    logic [7:0]          bus_q, bus_d;
    logic                op_q, op_d;
    logic                addr_q, addr_d;
    logic                stin_q, stin_d;
    logic                svc_q, svc_d;
    logic                asel_q, asel_d;
    logic                selin_q;

    logic                wr_en;
    logic [8:0]          sel_off;
    logic                in_range;
    logic [DEV_W-1:0]    sel_dev;
    logic [7:0]          rd_byte;
    logic                unused_ok;

    assign unused_ok = &{1'b0, b_hold_out, b_suppress_out};

    // 9-bit offset so addresses below the base cannot wrap into range
    assign sel_off  = {1'b0, b_bus_out} - {1'b0, BASE_ADDRESS};
    assign in_range = (b_bus_out >= BASE_ADDRESS) && (sel_off < 9'(NUM_DEVICES));
    assign sel_dev  = sel_off[DEV_W-1:0];

    // SENSE transfers one byte from the per-device sense register instead of the buffer
    assign rd_byte = (cmd_q == CMD_SENSE) ? sense_q[dev_q] : data_q[rd_ptr_q[BUF_AW-1:0]];

    always_comb begin
        state_d  = state_q;
        dev_d    = dev_q;
        cmd_d    = cmd_q;
        stat_d   = stat_q;
        fill_d   = fill_q;
        rd_ptr_d = rd_ptr_q;
        sense_d  = sense_q;
        bus_d    = bus_q;
        op_d     = op_q;
        addr_d   = addr_q;
        stin_d   = stin_q;
        svc_d    = svc_q;
        asel_d   = asel_q;
        wr_en    = 1'b0;

        if (state_q != S_IDLE && !b_operational_out) begin
            // Channel system reset: abandon the selection, keep buffer/fill/sense
            state_d = S_IDLE;
            op_d    = 1'b0;
            addr_d  = 1'b0;
            stin_d  = 1'b0;
            svc_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    op_d   = 1'b0;
                    addr_d = 1'b0;
                    stin_d = 1'b0;
                    svc_d  = 1'b0;
                    asel_d = b_select_out;
                    if (b_address_out && b_select_out && in_range) begin
                        dev_d  = sel_dev;
                        asel_d = 1'b0;
                        if (mock_busy[sel_dev] && ENABLE_SHORT_BUSY) begin
                            state_d = S_SB;
                            bus_d   = ST_SHORT_BUSY;
                            stin_d  = 1'b1;
                        end else begin
                            state_d = S_ADDR_WAIT;
                            op_d    = 1'b1;
                        end
                    end
                end
                S_SB: begin
                    if (b_service_out) begin
                        stin_d  = 1'b0;
                        state_d = S_SB_ACK;
                    end
                end
                S_SB_ACK: begin
                    if (!b_service_out) state_d = S_IDLE;
                end
                S_ADDR_WAIT: begin
                    if (!b_address_out) begin
                        bus_d   = BASE_ADDRESS + 8'(dev_q);
                        addr_d  = 1'b1;
                        state_d = S_ADDR_IN;
                    end
                end
                S_ADDR_IN: begin
                    if (b_command_out) begin
                        cmd_d   = b_bus_out;
                        addr_d  = 1'b0;
                        state_d = S_CMD_WAIT;
                    end
                end
                S_CMD_WAIT: begin
                    if (!b_command_out) state_d = S_DECODE;
                end
                S_DECODE: begin
                    if (mock_busy[dev_q]) begin
                        stat_d = ST_BUSY;
                    end else begin
                        case (cmd_q)
                            CMD_TEST:  stat_d = ST_NONE;
                            CMD_WRITE: begin
                                stat_d = ST_NONE;
                                fill_d = '0;
                            end
                            CMD_READ: begin
                                stat_d   = (fill_q == '0) ? ST_CEDE : ST_NONE;
                                rd_ptr_d = '0;
                            end
                            CMD_NOP:   stat_d = ST_CEDE;
                            CMD_SENSE: stat_d = ST_NONE;
                            default: begin
                                stat_d = ST_CEDE_UC;
                                sense_d[dev_q][7] = 1'b1;
                            end
                        endcase
                    end
                    bus_d   = stat_d;
                    stin_d  = 1'b1;
                    state_d = S_ST_INIT;
                end
                S_ST_INIT: begin
                    if (b_service_out) begin
                        stin_d  = 1'b0;
                        state_d = S_ST_INIT_ACK;
                    end
                end
                S_ST_INIT_ACK: begin
                    if (!b_service_out) begin
                        if (stat_q != ST_NONE || cmd_q == CMD_TEST) begin
                            op_d    = 1'b0;
                            state_d = S_IDLE;
                        end else if (cmd_q == CMD_WRITE) begin
                            svc_d   = 1'b1;
                            state_d = S_DIN;
                        end else begin
                            bus_d   = rd_byte;
                            svc_d   = 1'b1;
                            state_d = S_DOUT;
                        end
                    end
                end
                S_DOUT: begin
                    // Stop takes priority over an accepted byte in the same cycle
                    if (b_command_out) begin
                        svc_d   = 1'b0;
                        state_d = S_STOP;
                    end else if (b_service_out) begin
                        svc_d    = 1'b0;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        if (cmd_q == CMD_SENSE) sense_d[dev_q] = '0;
                        state_d  = S_DOUT_ACK;
                    end
                end
                S_DOUT_ACK: begin
                    if (!b_service_out) begin
                        if (cmd_q == CMD_SENSE || rd_ptr_q == fill_q) begin
                            bus_d   = ST_CEDE;
                            stin_d  = 1'b1;
                            state_d = S_ST_END;
                        end else begin
                            bus_d   = rd_byte;
                            svc_d   = 1'b1;
                            state_d = S_DOUT;
                        end
                    end
                end
                S_DIN: begin
                    if (b_command_out) begin
                        svc_d   = 1'b0;
                        state_d = S_STOP;
                    end else if (b_service_out) begin
                        wr_en   = 1'b1;
                        fill_d  = fill_q + 1'b1;
                        svc_d   = 1'b0;
                        state_d = S_DIN_ACK;
                    end
                end
                S_DIN_ACK: begin
                    if (!b_service_out) begin
                        // Ending here when full means a write at fill==BUFFER_DEPTH cannot happen
                        if (fill_q == FILL_W'(BUFFER_DEPTH)) begin
                            bus_d   = ST_CEDE;
                            stin_d  = 1'b1;
                            state_d = S_ST_END;
                        end else begin
                            svc_d   = 1'b1;
                            state_d = S_DIN;
                        end
                    end
                end
                S_STOP: begin
                    if (!b_command_out) begin
                        bus_d   = ST_CEDE;
                        stin_d  = 1'b1;
                        state_d = S_ST_END;
                    end
                end
                S_ST_END: begin
                    if (b_service_out) begin
                        stin_d  = 1'b0;
                        state_d = S_ST_END_ACK;
                    end
                end
                S_ST_END_ACK: begin
                    if (!b_service_out) begin
                        op_d    = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dev_q    <= '0;
            cmd_q    <= '0;
            stat_q   <= '0;
            fill_q   <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < NUM_DEVICES; i++) sense_q[i] <= '0;
            bus_q    <= '0;
            op_q     <= 1'b0;
            addr_q   <= 1'b0;
            stin_q   <= 1'b0;
            svc_q    <= 1'b0;
            asel_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dev_q    <= dev_d;
            cmd_q    <= cmd_d;
            stat_q   <= stat_d;
            fill_q   <= fill_d;
            rd_ptr_q <= rd_ptr_d;
            sense_q  <= sense_d;
            bus_q    <= bus_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            stin_q   <= stin_d;
            svc_q    <= svc_d;
            asel_q   <= asel_d;
        end
    end

    // Buffer contents survive reset; only fill says how much is valid
    always_ff @(posedge clk) begin
        if (wr_en) data_q[fill_q[BUF_AW-1:0]] <= b_bus_out;
    end

    // Downstream select return is re-timed continuously, reset or not
    always_ff @(posedge clk) begin
        selin_q <= a_select_in;
    end

    assign b_bus_in         = bus_q;
    assign b_operational_in = op_q;
    assign b_address_in     = addr_q;
    assign b_status_in      = stin_q;
    assign b_service_in     = svc_q;
    assign b_request_in     = 1'b0;
    assign b_select_in      = selin_q;
    assign a_select_out     = asel_q;

endmodule
